// File: rtl/mealy_pkg.sv
// mealy_pkg
//   Shared definitions for the Mealy job scheduler slice:
//     - controller state encoding (IDLE, CLEAR, RUN, DONE)
//     - detector core state encodings S00..S11 ({A,B})
//     - default job width
//     - pure next-state / output functions of the 2-bit Mealy detector
//   Ports: none (package).

package mealy_pkg;

  localparam int N_BITS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;

  // Detector transition table, state is {A,B}.
  function automatic logic [1:0] core_next(input logic [1:0] s, input logic x);
    logic [1:0] n;
    n = S00;
    case (s)
      S00:     n = x ? S01 : S00;
      S01:     n = x ? S10 : S11;
      S10:     n = x ? S11 : S00;
      S11:     n = x ? S11 : S10;
      default: n = S00;
    endcase
    return n;
  endfunction

  // y = ~B&(~A|~x) | B&~(A^x): 1 in S00, ~x in S01/S10, x in S11.
  function automatic logic core_out(input logic [1:0] s, input logic x);
    logic a;
    logic b;
    a = s[1];
    b = s[0];
    return (~b & (~a | ~x)) | (b & ~(a ^ x));
  endfunction

endpackage

// File: rtl/mealy_core.sv
// mealy_core
//   2-bit Mealy sequence-detector core. Steps on x only when en is high,
//   can be forced back to S00 synchronously with clr.
//   Ports:
//     clk    in   clock, rising edge
//     rst    in   asynchronous active-high reset (state -> S00)
//     clr    in   synchronous clear to S00, has priority over en
//     en     in   advance the state by one input bit
//     x      in   serial input bit
//     y      out  combinational Mealy output
//     state  out  current state {A,B}

module mealy_core
  import mealy_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       x,
  output logic       y,
  output logic [1:0] state
);

  logic [1:0] state_q;
  logic [1:0] state_d;

  // Next state: clear wins over stepping; otherwise hold.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S00;
    end else if (en) begin
      state_d = core_next(state_q, x);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S00;
    end else begin
      state_q <= state_d;
    end
  end

  assign y     = core_out(state_q, x);
  assign state = state_q;

endmodule

// File: rtl/mealy_job_sched.sv
// mealy_job_sched
//   Round-robin scheduler sharing one mealy_core between two requesters.
//   A granted job is streamed LSB-first into the core, one bit per clock,
//   and the core output for each bit is collected into res.
//   Ports:
//     clk, rst            clock / asynchronous active-high reset
//     req0, req1          level job requests, held until granted
//     data0, data1        job bits, bit 0 streamed first
//     len0, len1          job length, clamped to N_BITS when latched
//     gnt0, gnt1          one-cycle acceptance pulse (CLEAR cycle)
//     res                 collected y bits, zero above the job length
//     res_valid           one-cycle result strobe
//     res_id              requester owning the result
//     busy                high whenever the controller is not IDLE
//     core_state          core {A,B}, debug visibility

module mealy_job_sched
  import mealy_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int LW     = $clog2(N_BITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [N_BITS-1:0] data0,
  input  logic [N_BITS-1:0] data1,
  input  logic [LW-1:0]     len0,
  input  logic [LW-1:0]     len1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [N_BITS-1:0] res,
  output logic              res_valid,
  output logic              res_id,
  output logic              busy,
  output logic [1:0]        core_state
);

  localparam logic [LW-1:0] LEN_MAX = LW'(N_BITS);

  ctrl_state_e       state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              id_q, id_d;
  logic [N_BITS-1:0] data_q, data_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [N_BITS-1:0] res_q, res_d;

  logic              any_req;
  logic              win;
  logic [LW-1:0]     len_sel;
  logic [LW-1:0]     len_clamped;
  logic [LW-1:0]     len_last;
  logic [N_BITS-1:0] bit_sel;

  logic              core_clr;
  logic              core_en;
  logic              core_x;
  logic              core_y;
  logic [1:0]        core_st;

  // Arbitration: a lone request always wins; on a tie the pointer picks,
  // and ptr=0 means req0 is favoured.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      win = ptr_q;
    end else begin
      win = req1;
    end
    len_sel     = win ? len1 : len0;
    len_clamped = (len_sel > LEN_MAX) ? LEN_MAX : len_sel;
  end

  // One-hot select of the current bit keeps every index inside the vectors
  // regardless of the counter width.
  assign bit_sel  = N_BITS'(1) << cnt_q;
  assign len_last = len_q - LW'(1);

  // Controller next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    data_d   = data_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    core_clr = 1'b0;
    core_en  = 1'b0;
    core_x   = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = CLEAR;
          id_d    = win;
          data_d  = win ? data1 : data0;
          len_d   = len_clamped;
          cnt_d   = '0;
          res_d   = '0;
          ptr_d   = ~win;
        end
      end

      CLEAR: begin
        core_clr = 1'b1;
        state_d  = (len_q == '0) ? DONE : RUN;
      end

      RUN: begin
        core_en = 1'b1;
        core_x  = |(data_q & bit_sel);
        res_d   = core_y ? (res_q | bit_sel) : (res_q & ~bit_sel);
        if (cnt_q == len_last) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      data_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      data_q  <= data_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  mealy_core u_core (
    .clk   (clk),
    .rst   (rst),
    .clr   (core_clr),
    .en    (core_en),
    .x     (core_x),
    .y     (core_y),
    .state (core_st)
  );

  assign gnt0       = (state_q == CLEAR) & ~id_q;
  assign gnt1       = (state_q == CLEAR) &  id_q;
  assign res_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign res        = res_q;
  assign res_id     = id_q;
  assign core_state = core_st;

endmodule
